bpsk_demodulator: RTL and testbench

- Receive-side counterpart of the BPSK modulator: turns a stream of offset-binary carrier samples back into DATA_WIDTH-bit codewords for the Hamming decoder.
- Per bit: integrate-and-dump correlation against a square-wave reference over one carrier period, then a sign decision.
- Sits between the sample source (ADC or modulator loopback) and `hamming_decoder`; outputs a one-cycle `dv` per recovered word.

---
 rtl/bpsk_pkg.sv | 19 +
 rtl/bpsk_correlator.sv | 71 +++++++
 rtl/bpsk_demodulator.sv | 115 +++++++++++
 tb/tb_bpsk_demodulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: FSM state type, offset-binary midscale and
// correlator accumulator width (also used by the modulator).
package bpsk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic int midscale(input int sample_width);
    return 1 << (sample_width - 1);
  endfunction

  // One carrier period of full-scale samples summed with sign flips never overflows this width.
  function automatic int acc_width(input int sample_width, input int sample_number);
    return sample_width + $clog2(sample_number) + 1;
  endfunction

endpackage

// File: rtl/bpsk_correlator.sv
// Integrate-and-dump correlator against a square-wave reference, one bit per carrier period.
// BPSK_DEMOD_ERASURE_EN adds the low-magnitude flag bit_low.
module bpsk_correlator
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER   = 256,
  parameter int SAMPLE_WIDTH    = 12
`ifdef BPSK_DEMOD_ERASURE_EN
  ,
  parameter int ERASE_THRESHOLD = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    en,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] signal_in,
  output logic                    bit_valid,
  output logic                    bit_dec
`ifdef BPSK_DEMOD_ERASURE_EN
  ,
  output logic                    bit_low
`endif
);

  localparam int AW = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER);
  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam logic signed [SAMPLE_WIDTH:0] MID = (SAMPLE_WIDTH + 1)'(midscale(SAMPLE_WIDTH));

  logic [CW-1:0]              cnt_p0;
  logic signed [AW-1:0]       acc_p0;
  logic signed [AW-1:0]       contrib;
  logic signed [AW-1:0]       sum;
  logic signed [SAMPLE_WIDTH:0] s;

  // Second half of the carrier period correlates against the inverted reference.
  always_comb begin
    s       = $signed({1'b0, signal_in}) - MID;
    contrib = {{(AW - SAMPLE_WIDTH - 1){s[SAMPLE_WIDTH]}}, s};
    if (cnt_p0[CW-1]) contrib = -contrib;
    sum     = acc_p0 + contrib;
  end

  assign bit_valid = en && (&cnt_p0);
  assign bit_dec   = !sum[AW-1] && (sum != '0);

`ifdef BPSK_DEMOD_ERASURE_EN
  localparam logic [AW-1:0] THR = AW'(ERASE_THRESHOLD);

  function automatic logic [AW-1:0] magnitude(input logic signed [AW-1:0] x);
    return x[AW-1] ? -x : x;
  endfunction

  assign bit_low = magnitude(sum) < THR;
`endif

  // Stage p0: sample counter and running correlation, dumped after each bit.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (abort) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= cnt_p0 + 1'b1;
      acc_p0 <= bit_valid ? '0 : sum;
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK demodulator: correlator bit decisions assembled into DATA_WIDTH-bit words, MSB first.
// BPSK_DEMOD_ERASURE_EN adds the per-bit erasure mask output and ERASE_THRESHOLD.
module bpsk_demodulator
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER   = 256,
  parameter int SAMPLE_WIDTH    = 12,
  parameter int DATA_WIDTH      = 12
`ifdef BPSK_DEMOD_ERASURE_EN
  ,
  parameter int ERASE_THRESHOLD = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] signal_in,
  output logic                    dv,
  output logic [DATA_WIDTH-1:0]   q
`ifdef BPSK_DEMOD_ERASURE_EN
  ,
  output logic [DATA_WIDTH-1:0]   erasure
`endif
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] word;
  logic                  abort;
  logic                  bit_valid;
  logic                  bit_dec;

  assign abort = (state == ACCUM) && !en;
  assign word  = {shreg, bit_dec};

`ifdef BPSK_DEMOD_ERASURE_EN
  logic                  bit_low;
  logic [DATA_WIDTH-2:0] ers_shreg;
  logic [DATA_WIDTH-1:0] ers_word;

  assign ers_word = {ers_shreg, bit_low};
`endif

  bpsk_correlator #(
    .SAMPLE_NUMBER  (SAMPLE_NUMBER),
    .SAMPLE_WIDTH   (SAMPLE_WIDTH)
`ifdef BPSK_DEMOD_ERASURE_EN
    ,
    .ERASE_THRESHOLD(ERASE_THRESHOLD)
`endif
  ) u_corr (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .abort    (abort),
    .signal_in(signal_in),
    .bit_valid(bit_valid),
    .bit_dec  (bit_dec)
`ifdef BPSK_DEMOD_ERASURE_EN
    ,
    .bit_low  (bit_low)
`endif
  );

  // Stage p1: FSM, bit assembly and word output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      dv      <= 1'b0;
      q       <= '0;
`ifdef BPSK_DEMOD_ERASURE_EN
      ers_shreg <= '0;
      erasure   <= '0;
`endif
    end else begin
      dv <= 1'b0;
      case (state)
        IDLE:  if (en) state <= ACCUM;
        ACCUM: begin
          if (!en) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef BPSK_DEMOD_ERASURE_EN
            ers_shreg <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
      if (bit_valid) begin
        shreg <= word[DATA_WIDTH-2:0];
`ifdef BPSK_DEMOD_ERASURE_EN
        ers_shreg <= ers_word[DATA_WIDTH-2:0];
`endif
        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
          bit_cnt <= '0;
          q       <= word;
          dv      <= 1'b1;
`ifdef BPSK_DEMOD_ERASURE_EN
          erasure <= ers_word;
`endif
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: random sine frames with noise, aborts and resets.
module tb_bpsk_demodulator;

  localparam int N   = 256;
  localparam int SW  = 12;
  localparam int DW  = 12;
  localparam int THR = 4096;
  localparam int MID = 2048;

  logic          clk = 1'b0;
  logic          arst;
  logic          en;
  logic [SW-1:0] signal_in;
  logic          dv;
  logic [DW-1:0] q;
`ifdef BPSK_DEMOD_ERASURE_EN
  logic [DW-1:0] erasure;
`endif

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] ers;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            samp[DW*N];
  logic [DW-1:0] last_word = '0;

  bpsk_demodulator #(
    .SAMPLE_NUMBER  (N),
    .SAMPLE_WIDTH   (SW),
    .DATA_WIDTH     (DW)
`ifdef BPSK_DEMOD_ERASURE_EN
    ,
    .ERASE_THRESHOLD(THR)
`endif
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .signal_in(signal_in),
    .dv       (dv),
    .q        (q)
`ifdef BPSK_DEMOD_ERASURE_EN
    ,
    .erasure  (erasure)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Frame samples: each bit is one sine period, inverted for a 0, plus uniform noise.
  task automatic gen(input logic [DW-1:0] word, input int amp, input int noise);
    real v;
    int  x;
    for (int b = 0; b < DW; b++) begin
      for (int k = 0; k < N; k++) begin
        v = amp * $sin(2.0 * 3.14159265358979 * (k + 0.5) / N);
        if (!word[DW-1-b]) v = -v;
        x = MID + $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        if (noise > 0) x = x + int'($urandom_range(2 * noise)) - noise;
        if (x < 0) x = 0;
        if (x > 4095) x = 4095;
        samp[b*N+k] = x;
      end
    end
  endtask

  // Reference: signed correlation of each bit period with a +1/-1 half-period reference.
  task automatic model(output logic [DW-1:0] w, output logic [DW-1:0] e);
    longint sum;
    w = '0;
    e = '0;
    for (int b = 0; b < DW; b++) begin
      sum = 0;
      for (int k = 0; k < N; k++)
        sum += (k < N / 2) ? (samp[b*N+k] - MID) : -(samp[b*N+k] - MID);
      w[DW-1-b] = (sum > 0);
      e[DW-1-b] = ((sum < 0) ? -sum : sum) < THR;
    end
  endtask

  // mode 0: complete frame; mode 1: en dropped at abort_at; mode 2: arst pulsed at abort_at.
  task automatic send_frame(input logic [DW-1:0] word, input int amp, input int noise,
                            input int abort_at, input int mode);
    logic [DW-1:0] ew;
    logic [DW-1:0] ee;
    exp_t          x;
    gen(word, amp, noise);
    model(ew, ee);
    for (int i = 0; i < DW * N; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        if (mode == 2) begin
          arst = 1'b1;
          en   = 1'b0;
          #1;
          check("arst_dv", dv, 0);
          check("arst_q", q, 0);
`ifdef BPSK_DEMOD_ERASURE_EN
          check("arst_erasure", erasure, 0);
`endif
          @(negedge clk);
          arst = 1'b0;
        end else begin
          en = 1'b0;
        end
        return;
      end
      if (i == 0 && abort_at < 0) begin
        x.q   = ew;
        x.ers = ee;
        x.cyc = cyc + DW * N;
        sb.push_back(x);
        last_word = ew;
      end
      en        = 1'b1;
      signal_in = SW'(samp[i]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!arst && dv) begin
      if (sb.size() == 0) begin
        check("dv_unexpected", 32'(dv), 0);
      end else begin
        e = sb.pop_front();
        check("q", q, e.q);
        check("dv_cycle", cyc, e.cyc);
`ifdef BPSK_DEMOD_ERASURE_EN
        check("erasure", erasure, e.ers);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    arst      = 1'b1;
    en        = 1'b0;
    signal_in = SW'(MID);
    repeat (3) @(negedge clk);
    check("reset_dv", dv, 0);
    check("reset_q", q, 0);
`ifdef BPSK_DEMOD_ERASURE_EN
    check("reset_erasure", erasure, 0);
`endif
    arst = 1'b0;

    send_frame(12'hFFF, 2047, 0, -1, 0);
    send_frame(12'h000, 2047, 0, -1, 0);
    send_frame(12'hA5C, 1000, 50, -1, 0);
    send_frame(12'h000, 0, 0, -1, 0);

    send_frame(12'h5A5, 800, 20, 6 * N + 100, 1);
    @(posedge clk);
    #1;
    check("abort_q_kept", q, last_word);
    check("abort_dv", dv, 0);
    send_frame(12'h3C3, 1500, 30, -1, 0);

    send_frame(12'h2B7, 1200, 0, 1000, 2);
    send_frame(12'h6A1, 1800, 40, -1, 0);

    repeat (6) send_frame(12'($urandom_range(4095)), $urandom_range(200), $urandom_range(30), -1, 0);

    @(negedge clk);
    en = 1'b0;
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
